// File: rtl/mant_div_seq_if.sv
// Handshake and data bundle for the significand divider.
//
// Parameters:
//   MANT_W     stored mantissa width; significands are MANT_W+1 bits
//
// Signals:
//   in_valid   operands valid                        (master -> slave)
//   in_ready   divider idle, can accept              (slave -> master)
//   a_sig      dividend significand {hidden,mant}    (master -> slave)
//   b_sig      divisor significand {hidden,mant}     (master -> slave)
//   out_valid  result valid                          (slave -> master)
//   out_ready  consumer accepts result               (master -> slave)
//   quo        floor(X*2^(QW-1)/Y), QW = MANT_W+3    (slave -> master)
//   sticky     final remainder non-zero              (slave -> master)
//   dz         divide by zero                        (slave -> master)
//   ovf        X >= 2*Y, quotient does not fit       (slave -> master)
//
// Modports:
//   slave   the divider
//   master  the producer/consumer driving it
interface mant_div_seq_if #(
  parameter int MANT_W = 23
);
  localparam int QW = MANT_W + 3;

  logic              in_valid;
  logic              in_ready;
  logic [MANT_W:0]   a_sig;
  logic [MANT_W:0]   b_sig;
  logic              out_valid;
  logic              out_ready;
  logic [QW-1:0]     quo;
  logic              sticky;
  logic              dz;
  logic              ovf;

  modport slave (
    input  in_valid, a_sig, b_sig, out_ready,
    output in_ready, out_valid, quo, sticky, dz, ovf
  );

  modport master (
    output in_valid, a_sig, b_sig, out_ready,
    input  in_ready, out_valid, quo, sticky, dz, ovf
  );
endinterface

// File: rtl/mant_div_seq.sv
// Iterative restoring divider for floating-point significands.
//
// Takes normalized dividend/divisor significands (hidden bit included) and
// produces QW = MANT_W+3 quotient bits (integer bit, MANT_W fraction bits,
// guard, round) plus a sticky bit for the normalize/round stage. One
// operation in flight, valid/ready handshake on both sides.
//
// Parameters:
//   MANT_W   stored mantissa width (default 23)
//
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   flush    synchronous abort of the in-flight operation (highest priority)
//   bus      mant_div_seq_if.slave: in_valid/in_ready/a_sig/b_sig on the
//            request side, out_valid/out_ready/quo/sticky/dz/ovf on the
//            result side
//
// Build option:
//   MANT_DIV_R4_EN   when defined, two restoring steps are chained per clock
//                    (latency ceil(QW/2) instead of QW); results are
//                    bit-identical to the one-step-per-clock build.
module mant_div_seq #(
  parameter int MANT_W = 23
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  mant_div_seq_if.slave bus
);

  localparam int QW = MANT_W + 3;
  localparam int RW = MANT_W + 2;
  localparam int CW = $clog2(QW + 1);

  localparam logic [CW-1:0] CNT_INIT = CW'(QW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`ifdef MANT_DIV_R4_EN
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
`endif

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t          state;
  logic [RW-1:0]   rem;
  logic [MANT_W:0] div_y;
  logic [QW-1:0]   q;
  logic [CW-1:0]   cnt;

  logic            in_ready_q;
  logic            out_valid_q;
  logic [QW-1:0]   quo_q;
  logic            sticky_q;
  logic            dz_q;
  logic            ovf_q;

  // Operand classification at accept time. X >= 2Y means the integer part
  // of the quotient needs two bits, which the QW-bit result cannot hold.
  logic [RW-1:0]   a_ext;
  logic [RW-1:0]   b_dbl;
  logic            b_zero;
  logic            x_ovf;

  always_comb begin
    a_ext  = {1'b0, bus.a_sig};
    b_dbl  = {bus.b_sig, 1'b0};
    b_zero = (bus.b_sig == '0);
    x_ovf  = (a_ext >= b_dbl);
  end

  // One restoring step: compare, conditionally subtract, shift left.
  // Because rem < 2Y on entry, the post-subtract value is below Y, so the
  // left shift never loses a set bit out of RW bits.
  logic [RW-1:0] y_ext;
  logic          ge1;
  logic [RW-1:0] sel1;
  logic [RW-1:0] rem1;
  logic [QW-1:0] q1;

  always_comb begin
    y_ext = {1'b0, div_y};
    ge1   = (rem >= y_ext);
    sel1  = ge1 ? (rem - y_ext) : rem;
    rem1  = {sel1[RW-2:0], 1'b0};
    q1    = {q[QW-2:0], ge1};
  end

`ifdef MANT_DIV_R4_EN
  // Second step chained onto the first so two quotient bits retire per clock.
  logic          ge2;
  logic [RW-1:0] sel2;
  logic [RW-1:0] rem2;
  logic [QW-1:0] q2;

  always_comb begin
    ge2  = (rem1 >= y_ext);
    sel2 = ge2 ? (rem1 - y_ext) : rem1;
    rem2 = {sel2[RW-2:0], 1'b0};
    q2   = {q1[QW-2:0], ge2};
  end
`endif

  // Control FSM with registered handshake flags and result registers.
  // The result registers are only written on entry to DONE, so they hold
  // steady under backpressure and keep their last value after a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem         <= '0;
      div_y       <= '0;
      q           <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      sticky_q    <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            div_y <= bus.b_sig;
            rem   <= a_ext;
            cnt   <= CNT_INIT;
            q     <= '0;
            if (b_zero) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              quo_q       <= '1;
              sticky_q    <= 1'b0;
              dz_q        <= 1'b1;
              ovf_q       <= 1'b0;
            end else if (x_ovf) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              quo_q       <= '1;
              sticky_q    <= 1'b0;
              dz_q        <= 1'b0;
              ovf_q       <= 1'b1;
            end else begin
              state      <= ITER;
              in_ready_q <= 1'b0;
              dz_q       <= 1'b0;
              ovf_q      <= 1'b0;
            end
          end
        end

        ITER: begin
`ifdef MANT_DIV_R4_EN
          // With an odd QW the final clock has only one bit left to retire.
          if (cnt == CNT_ONE) begin
            rem         <= rem1;
            q           <= q1;
            cnt         <= cnt - CNT_ONE;
            state       <= DONE;
            out_valid_q <= 1'b1;
            quo_q       <= q1;
            sticky_q    <= (rem1 != '0);
          end else begin
            rem <= rem2;
            q   <= q2;
            cnt <= cnt - CNT_TWO;
            if (cnt == CNT_TWO) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              quo_q       <= q2;
              sticky_q    <= (rem2 != '0);
            end
          end
`else
          rem <= rem1;
          q   <= q1;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            quo_q       <= q1;
            sticky_q    <= (rem1 != '0);
          end
`endif
        end

        DONE: begin
          // in_ready rises only after the handshake edge, so a new operation
          // can never be accepted in the same cycle the result is taken.
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quo       = quo_q;
  assign bus.sticky    = sticky_q;
  assign bus.dz        = dz_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mant_div_seq.sv
// Self-checking bench for mant_div_seq (MANT_W=23, QW=26).
// Table-driven directed vectors plus hand-written sequences for
// backpressure, flush, and reset during an operation. Expected latency
// follows the MANT_DIV_R4_EN build option.
module tb_mant_div_seq;

  localparam int MANT_W = 23;
  localparam int QW     = MANT_W + 3;
`ifdef MANT_DIV_R4_EN
  localparam int ITER_LAT = (QW + 1) / 2;
`else
  localparam int ITER_LAT = QW;
`endif

  logic clk;
  logic rst_n;
  logic flush;

  mant_div_seq_if #(.MANT_W(MANT_W)) bus ();

  mant_div_seq #(.MANT_W(MANT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string           name;
    logic [MANT_W:0] a;
    logic [MANT_W:0] b;
    logic [QW-1:0]   quo;
    logic            sticky;
    logic            dz;
    logic            ovf;
    int              lat;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for in_ready, present operands, clock the accept edge.
  task automatic applyStimulus(input logic [MANT_W:0] a, input logic [MANT_W:0] b);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.a_sig    = a;
    bus.b_sig    = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a_sig    = '0;
    bus.b_sig    = '0;
  endtask

  // Count clock edges after the accept edge until out_valid shows up.
  task automatic waitResult(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic runVector(input vec_t v);
    int lat;
    applyStimulus(v.a, v.b);
    waitResult(lat);
    checkOutput({v.name, "_lat"},    64'(lat),        64'(v.lat));
    checkOutput({v.name, "_valid"},  64'(bus.out_valid), 64'd1);
    checkOutput({v.name, "_quo"},    64'(bus.quo),    64'(v.quo));
    checkOutput({v.name, "_sticky"}, 64'(bus.sticky), 64'(v.sticky));
    checkOutput({v.name, "_dz"},     64'(bus.dz),     64'(v.dz));
    checkOutput({v.name, "_ovf"},    64'(bus.ovf),    64'(v.ovf));
    @(posedge clk); #1;
    checkOutput({v.name, "_post_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({v.name, "_post_ready"}, 64'(bus.in_ready),  64'd1);
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0] = '{"one_one",     24'h800000, 24'h800000, 26'h2000000, 1'b0, 1'b0, 1'b0, ITER_LAT};
    vecs[1] = '{"one_1p5",     24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b0, 1'b0, ITER_LAT};
    vecs[2] = '{"1p5_one",     24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0, 1'b0, ITER_LAT};
    vecs[3] = '{"div_zero",    24'h800000, 24'h000000, 26'h3FFFFFF, 1'b0, 1'b1, 1'b0, 0};
    vecs[4] = '{"overflow",    24'h800000, 24'h400000, 26'h3FFFFFF, 1'b0, 1'b0, 1'b1, 0};
    vecs[5] = '{"max_by_one",  24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 1'b0, 1'b0, ITER_LAT};
    vecs[6] = '{"one_by_max",  24'h800000, 24'hFFFFFF, 26'h1000001, 1'b1, 1'b0, 1'b0, ITER_LAT};
    vecs[7] = '{"zero_dvd",    24'h000000, 24'h800000, 26'h0000000, 1'b0, 1'b0, 1'b0, ITER_LAT};
    vecs[8] = '{"six_sevenths",24'hC00000, 24'hE00000, 26'h1B6DB6D, 1'b1, 1'b0, 1'b0, ITER_LAT};
    vecs[9] = '{"zero_zero",   24'h000000, 24'h000000, 26'h3FFFFFF, 1'b0, 1'b1, 1'b0, 0};

    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_sig     = '0;
    bus.b_sig     = '0;
    bus.out_ready = 1'b1;

    #3;
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_quo",       64'(bus.quo),       64'd0);
    checkOutput("reset_sticky",    64'(bus.sticky),    64'd0);
    checkOutput("reset_dz",        64'(bus.dz),        64'd0);
    checkOutput("reset_ovf",       64'(bus.ovf),       64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);

    $display("[TB] running %0d table vectors", $size(vecs));
    for (int i = 0; i < $size(vecs); i++) begin
      runVector(vecs[i]);
    end

    // Backpressure: result must hold while out_ready is low; operands
    // offered meanwhile must be ignored.
    $display("[TB] backpressure sequence");
    bus.out_ready = 1'b0;
    applyStimulus(24'h800000, 24'hC00000);
    waitResult(lat);
    checkOutput("bp_lat", 64'(lat), 64'(ITER_LAT));
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.a_sig    = 24'hC00000;
      bus.b_sig    = 24'h800000;
      @(posedge clk); #1;
      checkOutput("bp_valid_held", 64'(bus.out_valid), 64'd1);
      checkOutput("bp_in_ready",   64'(bus.in_ready),  64'd0);
      checkOutput("bp_quo_held",   64'(bus.quo),       64'h1555555);
      checkOutput("bp_sticky_held",64'(bus.sticky),    64'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("bp_release_ready", 64'(bus.in_ready),  64'd1);
    @(posedge clk); #1;
    checkOutput("bp_nothing_latched", 64'(bus.in_ready), 64'd1);

    // Flush in the middle of ITER: no result, idle next cycle.
    $display("[TB] flush sequence");
    applyStimulus(24'h800000, 24'h800000);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_in_ready",  64'(bus.in_ready),  64'd1);
    checkOutput("flush_out_valid", 64'(bus.out_valid), 64'd0);
    seen = 0;
    for (int c = 0; c < QW + 4; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checkOutput("flush_no_result", 64'(seen), 64'd0);
    runVector(vecs[1]);

    // Flush together with in_valid in IDLE must not accept.
    bus.in_valid = 1'b1;
    bus.a_sig    = 24'h800000;
    bus.b_sig    = 24'h000000;
    flush        = 1'b1;
    @(posedge clk); #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_idle_ready", 64'(bus.in_ready),  64'd1);
    checkOutput("flush_idle_valid", 64'(bus.out_valid), 64'd0);

    // Reset mid-operation returns straight to reset values.
    $display("[TB] reset mid-operation");
    applyStimulus(24'hC00000, 24'h800000);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("rst_mid_ready", 64'(bus.in_ready),  64'd1);
    checkOutput("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_mid_quo",   64'(bus.quo),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    runVector(vecs[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
